// File: rtl/bus_packet_fifo_if.sv
// bus_packet_fifo_if
//   Captures NUM_CH-byte packets from a device-side source into a FIFO of
//   FIFO_DEPTH entries. The CPU sees the FIFO through a small register window
//   on the shared 8-bit tristate bus. An interrupt is raised on each accepted
//   push and is held until the CPU acknowledges it.
//
//   Optional feature macro: BUS_PACKET_FIFO_THRESHOLD_EN
//     When defined, CTRL[7:4] is a read/write push-count threshold T.
//     The interrupt is raised only when the FIFO count after a push is at
//     least max(T,1).
//
//   Register window (offset = BUS_ADDR - BASE_ADDR):
//     0 read   STATUS  {overflow, empty, full, count[4:0]}
//     0 write  COMMAND bit0 pop, bit1 clear overflow, bit2 flush
//     1 r/w    CTRL    bit0 IRQ_EN (reset 1), [7:4] threshold (optional)
//     2..      DATA    head packet byte (offset-2), 00 when empty
//
//   Ports:
//     CLK                  system clock, rising edge
//     RESET                asynchronous active-low reset
//     SRC_DATA/SRC_VALID   packet input and one-cycle push strobe
//     BUS_ADDR/BUS_DATA/BUS_WE   shared CPU bus
//     BUS_INTERRUPT_RAISE  interrupt request to the CPU
//     BUS_INTERRUPT_ACK    interrupt acknowledge from the CPU
module bus_packet_fifo_if #(
    parameter logic [7:0]  BASE_ADDR  = 8'hA0,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [8*NUM_CH-1:0] SRC_DATA,
    input  logic                SRC_VALID,
    input  logic [7:0]          BUS_ADDR,
    inout  wire  [7:0]          BUS_DATA,
    input  logic                BUS_WE,
    output logic                BUS_INTERRUPT_RAISE,
    input  logic                BUS_INTERRUPT_ACK
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    logic [8*NUM_CH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [4:0]          count, count_nxt;
    logic                overflow, irq_en;
    logic                rd_en;
    logic [7:0]          rd_data, rd_nxt;
    logic [7:0]          wr_data, status, ctrl_rd;

    // Address decode; 9-bit compare so a window at the top of the map cannot wrap.
    logic [8:0]            addr_lo, addr_hi;
    logic                  hit, wr_cmd, wr_ctrl;
    logic [ADDR_WIDTH-1:0] offset;

    assign addr_lo = {1'b0, BASE_ADDR};
    assign addr_hi = addr_lo + 9'(2**ADDR_WIDTH);
    assign hit     = ({1'b0, BUS_ADDR} >= addr_lo) && ({1'b0, BUS_ADDR} < addr_hi);
    assign offset  = BUS_ADDR[ADDR_WIDTH-1:0];
    assign wr_data = BUS_DATA;
    assign wr_cmd  = hit && BUS_WE && (offset == '0);
    assign wr_ctrl = hit && BUS_WE && (offset == ADDR_WIDTH'(1));

    logic unused_bits;
    assign unused_bits = &{1'b0, wr_data[7:3]};

    // FIFO control
    logic empty, full, flush, pop, push_ok, push_drop, irq_set;

    assign empty     = (count == 5'd0);
    assign full      = (count == 5'(FIFO_DEPTH));
    assign flush     = wr_cmd && wr_data[2];
    assign pop       = wr_cmd && wr_data[0] && !empty && !flush;
    // A pop in the same cycle frees the head slot, so a push at full still fits.
    assign push_ok   = SRC_VALID && !flush && (!full || pop);
    assign push_drop = SRC_VALID && !flush && full && !pop;
    assign count_nxt = flush ? 5'd0 : count + 5'(push_ok) - 5'(pop);

`ifdef BUS_PACKET_FIFO_THRESHOLD_EN
    logic [3:0] thr;
    logic [4:0] thr_min;
    assign thr_min = (thr == 4'd0) ? 5'd1 : {1'b0, thr};
    assign irq_set = push_ok && irq_en && (count_nxt >= thr_min);
    assign ctrl_rd = {thr, 3'b000, irq_en};
`else
    assign irq_set = push_ok && irq_en;
    assign ctrl_rd = {7'b0, irq_en};
`endif

    assign status = {overflow, empty, full, count};

    always_comb begin
        rd_nxt = 8'h00;
        if (offset == '0)
            rd_nxt = status;
        else if (offset == ADDR_WIDTH'(1))
            rd_nxt = ctrl_rd;
        else if (!empty) begin
            for (int k = 0; k < int'(NUM_CH); k++)
                if (int'(offset) == k + 2)
                    rd_nxt = mem[rd_ptr][8*k +: 8];
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            count               <= 5'd0;
            overflow            <= 1'b0;
            irq_en              <= 1'b1;
            BUS_INTERRUPT_RAISE <= 1'b0;
            rd_en               <= 1'b0;
            rd_data             <= 8'h00;
`ifdef BUS_PACKET_FIFO_THRESHOLD_EN
            thr                 <= 4'd0;
`endif
        end else begin
            count <= count_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop)     rd_ptr <= rd_ptr + 1'b1;
            end

            // A drop in the same cycle as a clear leaves the flag set.
            if (push_drop)
                overflow <= 1'b1;
            else if (wr_cmd && wr_data[1])
                overflow <= 1'b0;

            if (wr_ctrl) begin
                irq_en <= wr_data[0];
`ifdef BUS_PACKET_FIFO_THRESHOLD_EN
                thr    <= wr_data[7:4];
`endif
            end

            if (irq_set)
                BUS_INTERRUPT_RAISE <= 1'b1;
            else if (BUS_INTERRUPT_ACK)
                BUS_INTERRUPT_RAISE <= 1'b0;

            rd_en <= hit && !BUS_WE;
            if (hit && !BUS_WE)
                rd_data <= rd_nxt;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge CLK) begin
        if (push_ok)
            mem[wr_ptr] <= SRC_DATA;
    end

    // Release the bus whenever the CPU writes, even if a read response is pending.
    assign BUS_DATA = (rd_en && !BUS_WE) ? rd_data : 8'hzz;

endmodule

// File: tb/tb_bus_packet_fifo_if.sv
// Directed bench for bus_packet_fifo_if (default parameters: base A0,
// 4-byte packets, depth 8). The bus has pullups, so an undriven bus reads FF.
module tb_bus_packet_fifo_if;
    localparam logic [7:0] BASE = 8'hA0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] src_data = 32'h0;
    logic        src_valid = 1'b0;
    logic [7:0]  addr = 8'h00;
    logic        we = 1'b0;
    logic        ack = 1'b0;
    logic        drv_en = 1'b0;
    logic [7:0]  drv = 8'h00;
    wire  [7:0]  bus_data;
    wire         irq;

    int n_cmp = 0;
    int n_err = 0;

    assign bus_data = drv_en ? drv : 8'hzz;
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (bus_data[i]);
    end

    always #5 clk = ~clk;

    bus_packet_fifo_if dut (
        .CLK                 (clk),
        .RESET               (rst_n),
        .SRC_DATA            (src_data),
        .SRC_VALID           (src_valid),
        .BUS_ADDR            (addr),
        .BUS_DATA            (bus_data),
        .BUS_WE              (we),
        .BUS_INTERRUPT_RAISE (irq),
        .BUS_INTERRUPT_ACK   (ack)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
        addr = a; we = 1'b0;
        @(negedge clk);
        chk(tag, {24'h0, bus_data}, {24'h0, exp});
        addr = 8'h00;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d,
                      input logic with_push, input logic [31:0] pkt);
        addr = a; we = 1'b1; drv_en = 1'b1; drv = d;
        if (with_push) begin src_valid = 1'b1; src_data = pkt; end
        @(negedge clk);
        we = 1'b0; drv_en = 1'b0; src_valid = 1'b0; addr = 8'h00;
    endtask

    task automatic push(input logic [31:0] pkt);
        src_valid = 1'b1; src_data = pkt;
        @(negedge clk);
        src_valid = 1'b0;
    endtask

    task automatic do_ack(input logic with_push, input logic [31:0] pkt);
        ack = 1'b1;
        if (with_push) begin src_valid = 1'b1; src_data = pkt; end
        @(negedge clk);
        ack = 1'b0; src_valid = 1'b0;
    endtask

    task automatic idle(input string tag);
        @(negedge clk);
        chk(tag, {24'h0, bus_data}, 32'h0000_00FF);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_bus_z", {24'h0, bus_data}, 32'h0000_00FF);
        rst_n = 1'b1;
        rd(BASE, 8'h40, "status_after_reset");
        rd(BASE + 8'd1, 8'h01, "ctrl_after_reset");
        chk("irq_idle", {31'h0, irq}, 32'h0);
        idle("bus_z_idle");

        // Single packet
        push(32'h4433_2211);
        chk("irq_after_push", {31'h0, irq}, 32'h1);
        rd(BASE + 8'd2, 8'h11, "data0");
        rd(BASE + 8'd3, 8'h22, "data1");
        rd(BASE + 8'd4, 8'h33, "data2");
        rd(BASE + 8'd5, 8'h44, "data3");
        rd(BASE + 8'd6, 8'h00, "unused6");
        rd(BASE + 8'd7, 8'h00, "unused7");
        rd(BASE, 8'h01, "status_one");
        chk("irq_held", {31'h0, irq}, 32'h1);
        do_ack(1'b0, 32'h0);
        chk("irq_acked", {31'h0, irq}, 32'h0);
        wr(BASE, 8'h01, 1'b0, 32'h0);
        rd(BASE, 8'h40, "status_after_pop");
        rd(BASE + 8'd2, 8'h00, "data_empty");
        wr(BASE, 8'h01, 1'b0, 32'h0);
        rd(BASE, 8'h40, "pop_empty_ignored");

        // IRQ_EN off: no new request; off does not drop a raised one
        wr(BASE + 8'd1, 8'h00, 1'b0, 32'h0);
        rd(BASE + 8'd1, 8'h00, "ctrl_irq_off");
        push(32'hAAAA_AAAA);
        chk("irq_masked", {31'h0, irq}, 32'h0);
        wr(BASE + 8'd1, 8'h01, 1'b0, 32'h0);
        push(32'hBBBB_BBBB);
        chk("irq_unmasked", {31'h0, irq}, 32'h1);
        wr(BASE + 8'd1, 8'h00, 1'b0, 32'h0);
        chk("irq_kept_when_disabled", {31'h0, irq}, 32'h1);
        wr(BASE + 8'd1, 8'h01, 1'b0, 32'h0);
        wr(BASE, 8'h04, 1'b0, 32'h0);
        do_ack(1'b0, 32'h0);
        rd(BASE, 8'h40, "status_after_flush");

        // Overflow: nine pushes into depth 8
        for (int i = 1; i <= 9; i++)
            push({4{8'(i)}});
        rd(BASE, 8'hA8, "status_overflow");
        wr(BASE, 8'h02, 1'b0, 32'h0);
        rd(BASE, 8'h28, "status_ovf_cleared");
        rd(BASE + 8'd2, 8'h01, "head_first");

        // Full with push and pop together
        wr(BASE, 8'h01, 1'b1, 32'hEEEE_EEEE);
        rd(BASE, 8'h28, "full_push_pop");
        for (int j = 2; j <= 8; j++) begin
            rd(BASE + 8'd2, 8'(j), "head_seq");
            wr(BASE, 8'h01, 1'b0, 32'h0);
        end
        rd(BASE + 8'd5, 8'hEE, "late_packet");
        rd(BASE, 8'h01, "status_last");

        // Push together with ACK keeps the request; flush drops a same-cycle push
        do_ack(1'b0, 32'h0);
        chk("irq_clear2", {31'h0, irq}, 32'h0);
        do_ack(1'b1, 32'h5555_5555);
        chk("irq_set_beats_ack", {31'h0, irq}, 32'h1);
        rd(BASE, 8'h02, "status_two");
        wr(BASE, 8'h04, 1'b1, 32'h6666_6666);
        rd(BASE, 8'h40, "flush_with_push");

        // Decode boundaries
        rd(BASE + 8'd8, 8'hFF, "miss_above");
        rd(BASE - 8'd1, 8'hFF, "miss_below");
        wr(BASE + 8'd9, 8'h00, 1'b0, 32'h0);
        rd(BASE + 8'd1, 8'h01, "miss_write_ignored");

`ifdef BUS_PACKET_FIFO_THRESHOLD_EN
        wr(BASE + 8'd1, 8'h31, 1'b0, 32'h0);
        rd(BASE + 8'd1, 8'h31, "ctrl_thr");
        do_ack(1'b0, 32'h0);
        push(32'h0101_0101);
        chk("thr_push1", {31'h0, irq}, 32'h0);
        push(32'h0202_0202);
        chk("thr_push2", {31'h0, irq}, 32'h0);
        push(32'h0303_0303);
        chk("thr_push3", {31'h0, irq}, 32'h1);
`else
        wr(BASE + 8'd1, 8'hF1, 1'b0, 32'h0);
        rd(BASE + 8'd1, 8'h01, "ctrl_upper_ro");
`endif

        // Reset in the middle of a read releases the bus at once
        wr(BASE + 8'd1, 8'h00, 1'b0, 32'h0);
        push(32'h7777_7777);
        addr = BASE; we = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("rst_mid_read_bus", {24'h0, bus_data}, 32'h0000_00FF);
        addr = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid_irq", {31'h0, irq}, 32'h0);
        rd(BASE, 8'h40, "status_after_rst2");
        rd(BASE + 8'd1, 8'h01, "ctrl_after_rst2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bus_packet_fifo_if.md
Name: bus_packet_fifo_if

Overview:
Parametrised successor to the single-snapshot bus peripheral interface. It captures NUM_CH-byte packets from a device-side source (e.g. MouseTransceiver status/X/Y/Z) into a FIFO of FIFO_DEPTH entries, so movement events are not lost between CPU reads. It exposes status, control and head-of-FIFO registers on the shared 8-bit tristate bus, and raises a CPU interrupt that is held until the CPU acknowledges it.

Parameters:
BASE_ADDR, 8'hA0, first bus address of the register window
ADDR_WIDTH, 3, window size is 2**ADDR_WIDTH bytes; must satisfy 2+NUM_CH <= 2**ADDR_WIDTH
NUM_CH, 4, bytes per packet (1..6)
FIFO_DEPTH, 8, packet entries, power of two, 2..16

Ports:
CLK  in  1  system clock, all logic on rising edge
RESET  in  1  asynchronous, active-low reset
SRC_DATA  in  8*NUM_CH  packet, byte k at [8k+7:8k]
SRC_VALID  in  1  one-cycle push strobe (e.g. SendInterrupt)
BUS_ADDR  in  8  bus address
BUS_DATA  inout  8  tristate bus data
BUS_WE  in  1  bus write enable
BUS_INTERRUPT_RAISE  out  1  interrupt request to CPU
BUS_INTERRUPT_ACK  in  1  CPU acknowledge

Behaviour:
- Hit = BASE_ADDR <= BUS_ADDR < BASE_ADDR+2**ADDR_WIDTH; offset = BUS_ADDR[ADDR_WIDTH-1:0].
- Register map:
  - offset 0 STATUS (RO): [7] overflow (sticky), [6] empty, [5] full, [4:0] count.
  - offset 0 write = COMMAND: bit0 pop head, bit1 clear overflow, bit2 flush. Bits can combine.
  - offset 1 CTRL (RW): [0] IRQ_EN, reset 1; [7:1] read 0 unless the optional feature is enabled.
  - offsets 2..1+NUM_CH DATA (RO): head packet byte (offset-2). Reads 8'h00 when empty.
  - Unused offsets read 8'h00; writes to them are ignored.
- Read timing: a non-write hit in cycle N drives BUS_DATA in cycle N+1 with a value registered from cycle-N state. Otherwise BUS_DATA is Z, including during every write and on a miss. The bus is never driven in the cycle immediately after reset release.
- Push: SRC_VALID=1 writes the packet at the tail; count+1.
- Full push: the packet is dropped and overflow is set. If a pop occurs in the same cycle, the push is accepted instead and overflow is unchanged.
- Pop when empty: ignored.
- Push and pop in the same cycle with count>0: both take effect; count unchanged.
- Flush: count=0 and both pointers=0. A same-cycle push is dropped without setting overflow. Flush takes priority over pop.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is 5 bits, range 0..FIFO_DEPTH.
- Interrupt:
  - Set when an accepted push occurs and IRQ_EN=1.
  - Cleared on BUS_INTERRUPT_ACK.
  - Set has priority over ACK in the same cycle.
  - Clearing IRQ_EN does not drop an already raised request.
- Reset (RESET=0, asynchronous):
  - count, pointers, overflow = 0.
  - IRQ_EN = 1.
  - BUS_INTERRUPT_RAISE = 0.
  - Bus drive disabled (BUS_DATA = Z).
  - Read register = 0.
  - FIFO storage is not reset.
- Reset mid-packet or mid-read: any in-flight push or read is lost; the bus is released immediately.

Optional Feature:
Macro BUS_PACKET_FIFO_THRESHOLD_EN.
- With the macro: CTRL[7:4] is a RW threshold T, reset 0. Interrupt is set only by an accepted push whose resulting count >= max(T,1); CTRL reads back T.
- Without the macro: CTRL[7:4] reads 0 and writes are ignored. Every accepted push raises the interrupt.

Test Plan:
- Reset release, then read BASE+0 -> BUS_DATA=8'h40 one cycle later; BUS_INTERRUPT_RAISE=0; BUS_DATA=Z when idle.
- Push {8'h44,8'h33,8'h22,8'h11} (NUM_CH=4), read BASE+2..BASE+5 -> 11,22,33,44; STATUS=8'h01; IRQ=1 until ACK, then 0.
- Push 9 packets (depth 8) without popping -> STATUS=8'hA8, ninth packet absent; write 8'h02 to BASE+0 -> STATUS=8'h28.
- Full FIFO with push and pop in the same cycle -> count stays 8, overflow stays 0, new packet appears after 7 further pops.
- Push and ACK in the same cycle -> IRQ stays 1; write 8'h04 (flush) with a simultaneous push -> STATUS=8'h40, overflow 0.
- With BUS_PACKET_FIFO_THRESHOLD_EN, CTRL=8'h31 (T=3) -> pushes 1 and 2 give no IRQ, push 3 raises IRQ; address BASE+8 is not decoded (BUS_DATA=Z).
